// File: rtl/paeth_pkg.sv
// Shared types for the Paeth residual encoder: pixel/residual packing,
// predictor select codes and the block sequencing states.
package paeth_pkg;

    localparam int PIX_W = 10;
    localparam int RES_W = 11;

    typedef logic [3*PIX_W-1:0] pix_t;
    typedef logic [3*RES_W-1:0] res_t;

    typedef enum logic [1:0] {
        SEL_LEFT    = 2'd0,
        SEL_TOP     = 2'd1,
        SEL_TOPLEFT = 2'd2
    } paeth_sel_e;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN
    } state_e;

endpackage

// File: rtl/paeth_pick_1p.sv
// Single-plane Paeth selector: picks left, top or top-left, whichever lies
// closest to the gradient estimate T+L-TL. Purely combinational.
module paeth_pick_1p
    import paeth_pkg::*;
(
    input  logic [PIX_W-1:0] i_l,
    input  logic [PIX_W-1:0] i_t,
    input  logic [PIX_W-1:0] i_tl,
    output logic [PIX_W-1:0] o_pred,
    output paeth_sel_e       o_sel
);

    logic signed [11:0] w_l;
    logic signed [11:0] w_t;
    logic signed [11:0] w_tl;
    logic signed [11:0] w_base;
    logic signed [11:0] w_dl;
    logic signed [11:0] w_dt;
    logic signed [11:0] w_dtl;
    logic signed [11:0] w_pl;
    logic signed [11:0] w_pt;
    logic signed [11:0] w_ptl;

    // 12 bits hold base in -1023..2046 and base-TL in -2046..2046 without wrap
    assign w_l    = {2'b00, i_l};
    assign w_t    = {2'b00, i_t};
    assign w_tl   = {2'b00, i_tl};
    assign w_base = w_t + w_l - w_tl;
    assign w_dl   = w_base - w_l;
    assign w_dt   = w_base - w_t;
    assign w_dtl  = w_base - w_tl;
    assign w_pl   = w_dl[11]  ? -w_dl  : w_dl;
    assign w_pt   = w_dt[11]  ? -w_dt  : w_dt;
    assign w_ptl  = w_dtl[11] ? -w_dtl : w_dtl;

    always_comb begin
        o_pred = i_tl;
        o_sel  = SEL_TOPLEFT;
        if ((w_pl <= w_pt) && (w_pl <= w_ptl)) begin
            o_pred = i_l;
            o_sel  = SEL_LEFT;
        end else if (w_pt <= w_ptl) begin
            o_pred = i_t;
            o_sel  = SEL_TOP;
        end
    end

endmodule

// File: rtl/paeth_residual_enc.sv
// Paeth residual encoder: loads a block edge, then turns raster-order source
// pixels into signed residuals. PAETH_SAD_EN adds per-plane |residual| sums.
module paeth_residual_enc
    import paeth_pkg::*;
#(
    parameter int W = 8,
    parameter int H = 8
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       edge_valid,
    output logic       edge_ready,
    input  pix_t       edge_pix,
    input  logic       src_valid,
    output logic       src_ready,
    input  pix_t       src_pix,
    output logic       res_valid,
    input  logic       res_ready,
    output res_t       res_data,
    output logic [5:0] res_sel,
    output logic       res_last,
    output logic       busy
`ifdef PAETH_SAD_EN
    ,
    output logic [50:0] sad,
    output logic        sad_valid
`endif
);

    // state | meaning
    // IDLE  | waiting for start
    // LOAD  | taking 1+W+H edge beats: top-left, above[0..W-1], left[0..H-1]
    // RUN   | converting source pixels, one output register stage
    // DRAIN | all pixels taken, waiting for the last residual to leave

    localparam int BEATS  = 1 + W + H;
    localparam int BEAT_W = $clog2(1 + W + H + 1);
    localparam int COL_W  = $clog2(W);
    localparam int ROW_W  = $clog2(H);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [BEAT_W-1:0]  r_beat;
    logic [COL_W-1:0]   r_col;
    logic [ROW_W-1:0]   r_row;
    pix_t               r_tl;
    pix_t               r_above [W];
    pix_t               r_left  [H];
    logic               r_res_valid;
    res_t               r_res_data;
    logic [5:0]         r_res_sel;
    logic               r_res_last;

    logic               w_edge_hs;
    logic               w_src_hs;
    logic               w_res_hs;
    logic               w_last_beat;
    logic               w_last_pix;
    logic               w_start_ok;
    logic [COL_W-1:0]   w_above_idx;
    logic [ROW_W-1:0]   w_left_idx;
    pix_t               w_l_pix;
    pix_t               w_t_pix;
    res_t               w_res;
    logic [5:0]         w_sel;

    assign edge_ready  = (r_state == LOAD);
    assign src_ready   = (r_state == RUN) && (!r_res_valid || res_ready);
    assign busy        = (r_state != IDLE);
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_sel     = r_res_sel;
    assign res_last    = r_res_last;

    assign w_edge_hs   = edge_valid && edge_ready;
    assign w_src_hs    = src_valid && src_ready;
    assign w_res_hs    = r_res_valid && res_ready;
    assign w_start_ok  = (r_state == IDLE) && start;
    assign w_last_beat = (r_beat == BEAT_W'(BEATS - 1));
    assign w_last_pix  = (r_row == ROW_W'(H - 1)) && (r_col == COL_W'(W - 1));
    assign w_above_idx = COL_W'(r_beat - BEAT_W'(1));
    assign w_left_idx  = ROW_W'(r_beat - BEAT_W'(W + 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = LOAD;
            LOAD:    if (w_edge_hs && w_last_beat) w_state_nxt = RUN;
            RUN:     if (w_src_hs && w_last_pix) w_state_nxt = DRAIN;
            DRAIN:   if (w_res_hs && r_res_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_sel   <= '0;
            r_res_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_ok) begin
                r_beat <= '0;
                r_col  <= '0;
                r_row  <= '0;
            end
            if (w_edge_hs) begin
                r_beat <= r_beat + BEAT_W'(1);
            end
            if (w_src_hs) begin
                if (r_col == COL_W'(W - 1)) begin
                    r_col <= '0;
                    if (r_row != ROW_W'(H - 1)) begin
                        r_row <= r_row + ROW_W'(1);
                    end
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end
            // A new pixel only enters when the register is empty or draining
            if (w_src_hs) begin
                r_res_valid <= 1'b1;
                r_res_data  <= w_res;
                r_res_sel   <= w_sel;
                r_res_last  <= w_last_pix;
            end else if (res_ready) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    // Edge storage needs no reset; the beat counter restarts every block
    always_ff @(posedge clk) begin
        if (w_edge_hs) begin
            if (r_beat == '0) begin
                r_tl <= edge_pix;
            end else if (r_beat <= BEAT_W'(W)) begin
                r_above[w_above_idx] <= edge_pix;
            end else begin
                r_left[w_left_idx] <= edge_pix;
            end
        end
    end

    assign w_l_pix = r_left[r_row];
    assign w_t_pix = r_above[r_col];

    for (genvar p = 0; p < 3; p++) begin : g_plane
        logic [PIX_W-1:0] w_pred_p;
        paeth_sel_e       w_sel_p;

        paeth_pick_1p u_pick (
            .i_l    (w_l_pix[p*PIX_W +: PIX_W]),
            .i_t    (w_t_pix[p*PIX_W +: PIX_W]),
            .i_tl   (r_tl[p*PIX_W +: PIX_W]),
            .o_pred (w_pred_p),
            .o_sel  (w_sel_p)
        );

        assign w_res[p*RES_W +: RES_W] = {1'b0, src_pix[p*PIX_W +: PIX_W]} - {1'b0, w_pred_p};
        assign w_sel[2*p +: 2]         = w_sel_p;
    end

`ifdef PAETH_SAD_EN
    logic [16:0]      r_sad [3];
    logic [RES_W-1:0] w_abs [3];

    for (genvar p = 0; p < 3; p++) begin : g_abs
        assign w_abs[p] = w_res[p*RES_W + RES_W - 1] ? -w_res[p*RES_W +: RES_W]
                                                     :  w_res[p*RES_W +: RES_W];
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_start_ok) begin
            for (int p = 0; p < 3; p++) r_sad[p] <= '0;
        end else if (w_src_hs) begin
            for (int p = 0; p < 3; p++) r_sad[p] <= r_sad[p] + 17'(w_abs[p]);
        end
    end

    assign sad       = {r_sad[2], r_sad[1], r_sad[0]};
    assign sad_valid = w_res_hs && r_res_last;
`endif

endmodule

// File: tb/tb_paeth_residual_enc.sv
// Bench for paeth_residual_enc: uniform-edge vector table plus gradient,
// random, backpressure and mid-block reset sequences, scoreboard checked.
`timescale 1ns/1ps
module tb_paeth_residual_enc;
    import paeth_pkg::*;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int NPIX  = W * H;
    localparam int NBEAT = 1 + W + H;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       edge_valid;
    logic       edge_ready;
    pix_t       edge_pix;
    logic       src_valid;
    logic       src_ready;
    pix_t       src_pix;
    logic       res_valid;
    logic       res_ready;
    res_t       res_data;
    logic [5:0] res_sel;
    logic       res_last;
    logic       busy;
`ifdef PAETH_SAD_EN
    logic [50:0] sad;
    logic        sad_valid;
`endif

    always #5 clk = ~clk;

    paeth_residual_enc #(.W(W), .H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .edge_valid (edge_valid),
        .edge_ready (edge_ready),
        .edge_pix   (edge_pix),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_pix    (src_pix),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_sel    (res_sel),
        .res_last   (res_last),
`ifdef PAETH_SAD_EN
        .sad        (sad),
        .sad_valid  (sad_valid),
`endif
        .busy       (busy)
    );

    typedef struct {
        logic [9:0] tl;
        logic [9:0] t;
        logic [9:0] l;
        logic [9:0] src;
        int         exp_res;
        int         exp_sel;
    } vec_t;

    typedef struct packed {
        res_t       d;
        logic [5:0] s;
        logic       l;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    vec_t       tbl [8];
    pix_t       tb_tl;
    pix_t       tb_above [W];
    pix_t       tb_left  [H];
    pix_t       tb_src   [NPIX];
    res_t       exp_d    [NPIX];
    logic [5:0] exp_s    [NPIX];
    exp_t       sb [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void ref_pix(input int l, input int t, input int tl,
                                    output int pred, output int sel);
        int base, pl, pt, ptl;
        base = t + l - tl;
        pl   = (base > l)  ? base - l  : l - base;
        pt   = (base > t)  ? base - t  : t - base;
        ptl  = (base > tl) ? base - tl : tl - base;
        if (pl <= pt && pl <= ptl) begin
            pred = l;  sel = 0;
        end else if (pt <= ptl) begin
            pred = t;  sel = 1;
        end else begin
            pred = tl; sel = 2;
        end
    endfunction

    function automatic pix_t beat_pix(input int b);
        if (b == 0)  return tb_tl;
        if (b <= W)  return tb_above[b-1];
        return tb_left[b-W-1];
    endfunction

    task automatic fill_uniform(input logic [9:0] tl, input logic [9:0] t,
                                input logic [9:0] l, input logic [9:0] s);
        tb_tl = {tl, tl, tl};
        for (int i = 0; i < W; i++) tb_above[i] = {t, t, t};
        for (int i = 0; i < H; i++) tb_left[i]  = {l, l, l};
        for (int i = 0; i < NPIX; i++) tb_src[i] = {s, s, s};
    endtask

    task automatic fill_exp_const(input int r, input int s);
        for (int p = 0; p < NPIX; p++) begin
            exp_d[p] = {11'(r), 11'(r), 11'(r)};
            exp_s[p] = {2'(s), 2'(s), 2'(s)};
        end
    endtask

    task automatic fill_exp_model();
        int pred, sel, row, col;
        for (int p = 0; p < NPIX; p++) begin
            row = p / W;
            col = p % W;
            for (int k = 0; k < 3; k++) begin
                ref_pix(int'(tb_left[row][k*10 +: 10]), int'(tb_above[col][k*10 +: 10]),
                        int'(tb_tl[k*10 +: 10]), pred, sel);
                exp_d[p][k*11 +: 11] = 11'(int'(tb_src[p][k*10 +: 10]) - pred);
                exp_s[p][k*2 +: 2]   = 2'(sel);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_edge_ready"}, edge_ready, 0);
        check({tag, "_src_ready"},  src_ready,  0);
        check({tag, "_res_valid"},  res_valid,  0);
        check({tag, "_res_data"},   res_data,   0);
        check({tag, "_res_sel"},    res_sel,    0);
        check({tag, "_res_last"},   res_last,   0);
        check({tag, "_busy"},       busy,       0);
    endtask

    // mode 0: always ready; mode 1: ready toggles with a 20-cycle stall and source gaps
    task automatic run_block(input int mode, input int rst_at);
        int          beat, cyc, p_in, n_out, sad_cnt;
        bit          rst_pend, hold_pend;
        logic [39:0] hold_val;
        exp_t        e;
`ifdef PAETH_SAD_EN
        logic [50:0] sad_seen;
        int          sad_exp [3];
        sad_seen = '0;
`endif
        sb.delete();
        sad_cnt = 0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        beat = 0;
        cyc  = 0;
        while (beat < NBEAT && cyc < 200) begin
            edge_valid = (cyc % 5 != 4);
            edge_pix   = beat_pix(beat);
            @(negedge clk);
            if (edge_valid && edge_ready) beat++;
            @(posedge clk); #1;
            cyc++;
        end
        edge_valid = 1'b0;
        check("load_beats", beat, NBEAT);

        cyc = 0; p_in = 0; n_out = 0; rst_pend = 0; hold_pend = 0; hold_val = '0;
        while (n_out < NPIX && cyc < 3000 && !rst_pend) begin
            src_valid = (p_in < NPIX) && (mode == 0 || cyc % 7 != 6);
            src_pix   = tb_src[(p_in < NPIX) ? p_in : 0];
            res_ready = (mode == 0) ? 1'b1 : (cyc >= 40 && cyc < 60) ? 1'b0 : 1'(cyc % 2);
            start     = (cyc == 10);
            @(negedge clk);
            if (hold_pend && res_valid) check("hold_stable", {res_data, res_sel, res_last}, hold_val);
            if (res_valid && !res_ready) check("stall_src_ready", src_ready, 0);
            if (res_valid && res_ready) begin
                check("sb_has_entry", sb.size() > 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("res_data", res_data, e.d);
                    check("res_sel",  res_sel,  e.s);
                    check("res_last", res_last, e.l);
                end
                n_out++;
            end
`ifdef PAETH_SAD_EN
            if (sad_valid) begin
                sad_cnt++;
                sad_seen = sad;
            end
`endif
            hold_pend = res_valid && !res_ready;
            hold_val  = {res_data, res_sel, res_last};
            if (src_valid && src_ready) begin
                sb.push_back('{d: exp_d[p_in], s: exp_s[p_in], l: (p_in == NPIX - 1)});
                if (p_in == rst_at) rst_pend = 1;
                p_in++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start     = 1'b0;
        src_valid = 1'b0;
        res_ready = 1'b1;
        if (rst_pend) begin
            rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs("midrst");
            @(posedge clk); #1 rst_n = 1'b1;
            sb.delete();
            return;
        end
        check("res_count", n_out, NPIX);
        check("sb_empty", sb.size(), 0);
        @(negedge clk);
        check("busy_end", busy, 0);
        check("res_valid_end", res_valid, 0);
`ifdef PAETH_SAD_EN
        sad_exp = '{0, 0, 0};
        for (int p = 0; p < NPIX; p++)
            for (int k = 0; k < 3; k++) begin
                int r;
                r = int'($signed(exp_d[p][k*11 +: 11]));
                sad_exp[k] += (r < 0) ? -r : r;
            end
        check("sad_pulses", sad_cnt, 1);
        check("sad_value", sad_seen, {17'(sad_exp[2]), 17'(sad_exp[1]), 17'(sad_exp[0])});
`else
        check("sad_pulses", sad_cnt, 0);
`endif
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; edge_valid = 1'b0; edge_pix = '0;
        src_valid = 1'b0; src_pix = '0; res_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("por");
        @(posedge clk); #1 rst_n = 1'b1;

        tbl[0] = '{tl: 10'd512,  t: 10'd512,  l: 10'd512,  src: 10'd520,  exp_res:     8, exp_sel: 0};
        tbl[1] = '{tl: 10'd0,    t: 10'd1023, l: 10'd1023, src: 10'd0,    exp_res: -1023, exp_sel: 0};
        tbl[2] = '{tl: 10'd1023, t: 10'd0,    l: 10'd0,    src: 10'd1023, exp_res:  1023, exp_sel: 0};
        tbl[3] = '{tl: 10'd100,  t: 10'd200,  l: 10'd100,  src: 10'd150,  exp_res:   -50, exp_sel: 1};
        tbl[4] = '{tl: 10'd50,   t: 10'd100,  l: 10'd0,    src: 10'd60,   exp_res:    10, exp_sel: 2};
        tbl[5] = '{tl: 10'd0,    t: 10'd0,    l: 10'd1023, src: 10'd0,    exp_res: -1023, exp_sel: 0};
        tbl[6] = '{tl: 10'd500,  t: 10'd510,  l: 10'd490,  src: 10'd1000, exp_res:   500, exp_sel: 2};
        tbl[7] = '{tl: 10'd100,  t: 10'd80,   l: 10'd110,  src: 10'd80,   exp_res:     0, exp_sel: 1};

        for (int i = 0; i < 8; i++) begin
            fill_uniform(tbl[i].tl, tbl[i].t, tbl[i].l, tbl[i].src);
            fill_exp_const(tbl[i].exp_res, tbl[i].exp_sel);
            run_block(i % 2, -1);
        end

        tb_tl = {10'd100, 10'd100, 10'd100};
        for (int c = 0; c < W; c++) tb_above[c] = {3{10'(100 + 10 * c)}};
        for (int r = 0; r < H; r++) tb_left[r] = {10'd100, 10'd100, 10'd100};
        for (int p = 0; p < NPIX; p++) tb_src[p] = tb_above[p % W];
        fill_exp_model();
        run_block(0, -1);
        run_block(1, -1);

        for (int n = 0; n < 2; n++) begin
            tb_tl = pix_t'({10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))});
            for (int c = 0; c < W; c++)
                tb_above[c] = pix_t'({10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))});
            for (int r = 0; r < H; r++)
                tb_left[r] = pix_t'({10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))});
            for (int p = 0; p < NPIX; p++)
                tb_src[p] = pix_t'({10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023))});
            fill_exp_model();
            run_block(1, -1);
        end

        fill_uniform(10'd512, 10'd512, 10'd512, 10'd520);
        fill_exp_const(8, 0);
        run_block(1, 30);
        run_block(1, -1);
        run_block(0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
